// File: rtl/dfswt_peak_seq_if.sv
// Frame/result handshake bundle between the sliding-DFT stage array and dfswt_peak_seq.
// master drives frames in and consumes results; slave is the peak sequencer.
interface dfswt_peak_seq_if #(
  parameter int BINS  = 4,
  parameter int BIN_W = 2,
  parameter int MAG_W = 32
);
  logic                  enable;
  logic                  mag_valid;
  logic [BINS*MAG_W-1:0] mag_flat;
  logic [MAG_W-1:0]      threshold;
  logic                  busy;
  logic                  peak_valid;
  logic [BIN_W-1:0]      freqbin;
  logic [MAG_W-1:0]      peakmag;
  logic                  detect;
  logic                  overrun;

  modport master (
    output enable, mag_valid, mag_flat, threshold,
    input  busy, peak_valid, freqbin, peakmag, detect, overrun
  );

  modport slave (
    input  enable, mag_valid, mag_flat, threshold,
    output busy, peak_valid, freqbin, peakmag, detect, overrun
  );
endinterface

// File: rtl/dfswt_peak_seq.sv
// Sequential peak-bin picker: snapshots one magnitude frame, scans one bin per cycle.
// Optional hysteresis on the reported bin is enabled by defining DFSWT_HYST_EN.
module dfswt_peak_seq #(
  parameter int BINS       = 4,
  parameter int BIN_W      = 2,
  parameter int MAG_W      = 32,
  parameter int HYST_SHIFT = 3
) (
  input  logic             clock,
  input  logic             reset,
  dfswt_peak_seq_if.slave  bus
);
  localparam int IDX_W = BIN_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [MAG_W-1:0] best_reg;
  logic [BIN_W-1:0] bestidx_reg;
  logic             busy_reg;
  logic             peak_valid_reg;
  logic [BIN_W-1:0] freqbin_reg;
  logic [MAG_W-1:0] peakmag_reg;
  logic             detect_reg;
  logic             overrun_reg;

  logic [MAG_W-1:0] mag_in [BINS];
  logic [MAG_W-1:0] snap_reg [BINS];
  logic [MAG_W-1:0] thr_reg;
  logic [MAG_W-1:0] cur_mag;
  logic             accept;

  assign accept  = bus.enable && bus.mag_valid && (state_reg == ST_IDLE);
  assign cur_mag = snap_reg[idx_reg[BIN_W-1:0]];

  // Snapshot storage carries no reset: it is only read after a fresh capture.
  genvar gi;
  generate
    for (gi = 0; gi < BINS; gi++) begin : g_snap
      assign mag_in[gi] = bus.mag_flat[gi*MAG_W +: MAG_W];
      always_ff @(posedge clock) begin
        if (accept) snap_reg[gi] <= mag_in[gi];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (accept) thr_reg <= bus.threshold;
  end

`ifdef DFSWT_HYST_EN
  logic [MAG_W-1:0] heldmag_reg;
  logic [MAG_W:0]   hyst_lim;
  logic             keep_held;

  assign hyst_lim  = {1'b0, heldmag_reg} + {1'b0, heldmag_reg >> HYST_SHIFT};
  assign keep_held = (bestidx_reg != freqbin_reg) && ({1'b0, best_reg} <= hyst_lim);

  // freqbin is frozen during a scan, so exactly one scan step matches it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      heldmag_reg <= '0;
    end else if (bus.enable && state_reg == ST_SCAN &&
                 idx_reg[BIN_W-1:0] == freqbin_reg) begin
      heldmag_reg <= cur_mag;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      best_reg       <= '0;
      bestidx_reg    <= '0;
      busy_reg       <= 1'b0;
      peak_valid_reg <= 1'b0;
      freqbin_reg    <= '0;
      peakmag_reg    <= '0;
      detect_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      peak_valid_reg <= 1'b0;
      if (bus.enable) begin
        if (bus.mag_valid && state_reg != ST_IDLE) overrun_reg <= 1'b1;
        case (state_reg)
          ST_IDLE: begin
            if (bus.mag_valid) begin
              idx_reg     <= '0;
              best_reg    <= '0;
              bestidx_reg <= '0;
              busy_reg    <= 1'b1;
              state_reg   <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (cur_mag > best_reg) begin
              best_reg    <= cur_mag;
              bestidx_reg <= idx_reg[BIN_W-1:0];
            end
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) state_reg <= ST_DONE;
          end
          ST_DONE: begin
`ifdef DFSWT_HYST_EN
            if (keep_held) begin
              peakmag_reg <= heldmag_reg;
              detect_reg  <= heldmag_reg > thr_reg;
            end else begin
              freqbin_reg <= bestidx_reg;
              peakmag_reg <= best_reg;
              detect_reg  <= best_reg > thr_reg;
            end
`else
            freqbin_reg <= bestidx_reg;
            peakmag_reg <= best_reg;
            detect_reg  <= best_reg > thr_reg;
`endif
            peak_valid_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.peak_valid = peak_valid_reg;
  assign bus.freqbin    = freqbin_reg;
  assign bus.peakmag    = peakmag_reg;
  assign bus.detect     = detect_reg;
  assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_dfswt_peak_seq.sv
// Self-checking bench for dfswt_peak_seq (BINS=4): directed scenarios plus random back-to-back frames.
// Expected results come from a plain argmax model with the hold-bin rule when DFSWT_HYST_EN is defined.
module tb_dfswt_peak_seq;
  typedef logic [31:0] frame_t [4];

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // model: currently reported outputs (m_*) and the result expected from the pending frame (e_*)
  logic [1:0]  m_fb = '0, e_fb;
  logic [31:0] m_pm = '0, e_pm;
  logic        m_det = 1'b0, e_det;

  dfswt_peak_seq_if #(.BINS(4), .BIN_W(2), .MAG_W(32)) bus ();

  dfswt_peak_seq #(.BINS(4), .BIN_W(2), .MAG_W(32), .HYST_SHIFT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model(input frame_t f, input logic [31:0] thr);
    logic [31:0] best;
    int          bi;
    logic [31:0] held;
    logic [32:0] lim;
    best = '0;
    bi   = 0;
    for (int i = 0; i < 4; i++) if (f[i] > best) begin best = f[i]; bi = i; end
    e_fb = 2'(bi);
    e_pm = best;
    held = f[m_fb];
    lim  = {1'b0, held} + {1'b0, held >> 3};
`ifdef DFSWT_HYST_EN
    if (2'(bi) != m_fb && {1'b0, best} <= lim) begin e_fb = m_fb; e_pm = held; end
`endif
    e_det = e_pm > thr;
  endtask

  task automatic start_frame(input frame_t f, input logic [31:0] thr);
    for (int i = 0; i < 4; i++) bus.mag_flat[i*32 +: 32] = f[i];
    bus.threshold = thr;
    bus.mag_valid = 1'b1;
    model(f, thr);
    tick();
    bus.mag_valid = 1'b0;
  endtask

  // Waits for peak_valid; between pulses the held outputs must not move.
  task automatic wait_peak(input int maxc, output int lat, output int busyc);
    lat = -1;
    busyc = 0;
    for (int k = 1; k <= maxc; k++) begin
      if (bus.busy) busyc++;
      tick();
      if (bus.peak_valid) begin lat = k; break; end
      n_checks++;
      if (bus.freqbin !== m_fb || bus.peakmag !== m_pm || bus.detect !== m_det) begin
        n_fail++;
        $display("FAIL hold_stable: got fb=%0d pm=%0d det=%0b, need fb=%0d pm=%0d det=%0b",
                 bus.freqbin, bus.peakmag, bus.detect, m_fb, m_pm, m_det);
      end
    end
    if (lat < 0) $display("FAIL peak_timeout: no peak_valid within %0d cycles", maxc);
    m_fb = e_fb; m_pm = e_pm; m_det = e_det;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.mag_valid = 1'b0; bus.mag_flat = '0; bus.threshold = '0;
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({bus.busy, bus.peak_valid, bus.freqbin, bus.peakmag, bus.detect, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b pv=%0b fb=%0d pm=%0d det=%0b ovr=%0b, need all 0",
               bus.busy, bus.peak_valid, bus.freqbin, bus.peakmag, bus.detect, bus.overrun);
    end
    reset = 1'b1;
    tick();
    m_fb = '0; m_pm = '0; m_det = 1'b0;
  endtask

  task automatic test_basic(input frame_t f, input logic [31:0] thr, input string tag);
    int lat, busyc;
    start_frame(f, thr);
    wait_peak(12, lat, busyc);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL %s_latency: got %0d edges, need 5", tag, lat); end
    n_checks++;
    if (busyc !== 5) begin n_fail++; $display("FAIL %s_busy: got %0d cycles, need 5", tag, busyc); end
    n_checks++;
    if (bus.freqbin !== e_fb) begin n_fail++; $display("FAIL %s_freqbin: got %0d, need %0d", tag, bus.freqbin, e_fb); end
    n_checks++;
    if (bus.peakmag !== e_pm) begin n_fail++; $display("FAIL %s_peakmag: got %0d, need %0d", tag, bus.peakmag, e_pm); end
    n_checks++;
    if (bus.detect !== e_det) begin n_fail++; $display("FAIL %s_detect: got %0b, need %0b", tag, bus.detect, e_det); end
    $display("frame %s: fb=%0d pm=%0d det=%0b lat=%0d", tag, bus.freqbin, bus.peakmag, bus.detect, lat);
  endtask

  task automatic test_enable_stall();
    frame_t f = '{0, 0, 9, 0};
    int lat, busyc;
    start_frame(f, 32'd5);
    tick(); tick();
    bus.enable = 1'b0;
    bus.mag_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.mag_valid = 1'b0;
      n_checks++;
      if (bus.peak_valid !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_frozen: pv=%0b busy=%0b, need pv=0 busy=1", bus.peak_valid, bus.busy);
      end
    end
    bus.enable = 1'b1;
    wait_peak(12, lat, busyc);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL stall_latency: got %0d remaining edges, need 3", lat); end
    n_checks++;
    if (bus.freqbin !== e_fb || bus.peakmag !== e_pm) begin
      n_fail++; $display("FAIL stall_result: got fb=%0d pm=%0d, need fb=%0d pm=%0d", bus.freqbin, bus.peakmag, e_fb, e_pm);
    end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL stall_no_overrun: got %0b, need 0", bus.overrun); end
    $display("frame stall: fb=%0d pm=%0d", bus.freqbin, bus.peakmag);
  endtask

  task automatic test_idle_ignore();
    bus.enable = 1'b0; bus.mag_valid = 1'b1;
    tick(); tick();
    bus.enable = 1'b1; bus.mag_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.peak_valid !== 1'b0 || bus.overrun !== 1'b0) begin
        n_fail++; $display("FAIL idle_ignore: busy=%0b pv=%0b ovr=%0b, need all 0", bus.busy, bus.peak_valid, bus.overrun);
      end
    end
    $display("idle mag_valid with enable low ignored");
  endtask

  task automatic test_back_to_back();
    frame_t f;
    logic [31:0] thr;
    int lat, busyc;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) f[i] = (n % 3 == 0) ? $urandom : $urandom_range(0, 15);
      thr = (n % 3 == 0) ? $urandom : $urandom_range(0, 15);
      start_frame(f, thr);
      wait_peak(12, lat, busyc);
      n_checks++;
      if (lat !== 5 || bus.freqbin !== e_fb || bus.peakmag !== e_pm || bus.detect !== e_det) begin
        n_fail++;
        $display("FAIL b2b_%0d: got lat=%0d fb=%0d pm=%0d det=%0b, need lat=5 fb=%0d pm=%0d det=%0b",
                 n, lat, bus.freqbin, bus.peakmag, bus.detect, e_fb, e_pm, e_det);
      end
      $display("b2b %0d: frame {%0d,%0d,%0d,%0d} thr=%0d -> fb=%0d pm=%0d det=%0b",
               n, f[0], f[1], f[2], f[3], thr, bus.freqbin, bus.peakmag, bus.detect);
    end
  endtask

  task automatic test_overrun();
    frame_t f = '{1, 2, 3, 4};
    int lat, busyc, pulses;
    start_frame(f, 32'd0);
    tick(); tick();
    bus.mag_flat = {4{32'd100}};
    bus.mag_valid = 1'b1;
    tick();
    bus.mag_valid = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0b, need 1", bus.overrun); end
    wait_peak(12, lat, busyc);
    n_checks++;
    if (lat !== 2 || bus.freqbin !== e_fb || bus.peakmag !== e_pm) begin
      n_fail++; $display("FAIL overrun_result: got lat=%0d fb=%0d pm=%0d, need lat=2 fb=%0d pm=%0d",
                         lat, bus.freqbin, bus.peakmag, e_fb, e_pm);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (bus.peak_valid) pulses++; end
    n_checks++;
    if (pulses !== 0 || bus.overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_single: extra pulses=%0d ovr=%0b, need 0 and 1", pulses, bus.overrun);
    end
    $display("overrun frame: fb=%0d pm=%0d ovr=%0b", bus.freqbin, bus.peakmag, bus.overrun);
  endtask

  task automatic test_reset_midscan();
    frame_t f = '{5, 6, 7, 8};
    int pulses;
    start_frame(f, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.peak_valid, bus.freqbin, bus.peakmag, bus.detect, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset: busy=%0b pv=%0b fb=%0d pm=%0d det=%0b ovr=%0b, need all 0",
               bus.busy, bus.peak_valid, bus.freqbin, bus.peakmag, bus.detect, bus.overrun);
    end
    m_fb = '0; m_pm = '0; m_det = 1'b0;
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (bus.peak_valid) pulses++; end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midscan_no_pulse: got %0d pulses, need 0", pulses); end
    $display("reset mid-scan aborted frame");
  endtask

`ifdef DFSWT_HYST_EN
  task automatic test_hyst();
    frame_t f;
    logic [1:0]  need_fb [3] = '{2'd1, 2'd1, 2'd2};
    logic [31:0] need_pm [3] = '{32'd80, 32'd80, 32'd95};
    logic [31:0] third  [3] = '{32'd0, 32'd85, 32'd95};
    int lat, busyc;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    m_fb = '0; m_pm = '0; m_det = 1'b0;
    for (int n = 0; n < 3; n++) begin
      f = '{0, 80, 0, 0};
      f[2] = third[n];
      start_frame(f, 32'd50);
      wait_peak(12, lat, busyc);
      n_checks++;
      if (bus.freqbin !== need_fb[n] || bus.peakmag !== need_pm[n] || bus.detect !== 1'b1) begin
        n_fail++; $display("FAIL hyst_%0d: got fb=%0d pm=%0d det=%0b, need fb=%0d pm=%0d det=1",
                           n, bus.freqbin, bus.peakmag, bus.detect, need_fb[n], need_pm[n]);
      end
      $display("hyst %0d: fb=%0d pm=%0d", n, bus.freqbin, bus.peakmag);
    end
  endtask
`endif

  initial begin
    frame_t f_basic = '{10, 50, 30, 20};
    frame_t f_tie   = '{7, 7, 3, 7};
    frame_t f_zero  = '{0, 0, 0, 0};
    test_reset();
    test_basic(f_basic, 32'd40, "basic");
    test_basic(f_tie, 32'd7, "tie");
    test_enable_stall();
    test_idle_ignore();
    test_back_to_back();
    test_overrun();
    test_reset_midscan();
    test_basic(f_zero, 32'd0, "zero");
`ifdef DFSWT_HYST_EN
    test_hyst();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
